// File: rtl/interrupt_ack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : interrupt_ack_sequencer
//  Purpose  : Acknowledge controller for an 8259-style PIC. Resolves fixed
//             priority (IR0 highest) of unmasked requests against the
//             in-service register, raises INT, runs the INTA pulse sequence,
//             freezes and clears the request register, owns the ISR, drives
//             the interrupt vector and handles EOI (specific, non-specific,
//             automatic).
//  Ports    : clk, rst                     - clock, async active-high reset
//             interrupt_request_register   - IRR from the request block
//             interrupt_mask               - IMR, 1 = level masked
//             interrupt_acknowledge_n      - INTA, active-low, synchronous
//             vector_base                  - vector bits [7:3]
//             auto_eoi                     - clear ISR bit at end of ack
//             eoi_cmd / specific_eoi /
//             eoi_level                    - EOI command strobe and qualifiers
//             int_out                      - INT to the CPU
//             freeze                       - holds the IRR during acknowledge
//             clear_IRR                    - one-hot, one-cycle IRR clear
//             in_service_register          - ISR
//             vector_out / vector_oe       - vector byte and its enable
//  Revision : 1.0 - initial release
// ============================================================================
module interrupt_ack_sequencer #(
    parameter int INTA_PULSES = 2,
    parameter int SPURIOUS_ID = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic       interrupt_acknowledge_n,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       eoi_cmd,
    input  logic       specific_eoi,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic       freeze,
    output logic [7:0] clear_IRR,
    output logic [7:0] in_service_register,
    output logic [7:0] vector_out,
    output logic       vector_oe
);

    localparam logic [2:0] C_SPURIOUS_LVL = 3'(SPURIOUS_ID);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        ACK1 = 3'd2,
        GAP  = 3'd3,
        ACK2 = 3'd4
    } state_t;

    state_t     state_q;
    logic       inta_q;
    logic [2:0] id_q;
    logic       id_valid_q;
    logic [7:0] isr_q;
    logic       int_out_q;
    logic       freeze_q;
    logic [7:0] clear_irr_q;
    logic [7:0] vector_out_q;
    logic       vector_oe_q;

    // Index of the lowest set bit, or 8 when the vector is empty. Returning 8
    // for "none" lets an empty ISR compare as lower priority than any level.
    function automatic logic [3:0] lowest_set(input logic [7:0] v);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    logic [3:0] req_low;
    logic [3:0] isr_low;
    logic       cand_valid;
    logic       inta_fall;
    logic       inta_rise;
    logic       ack_take;
    logic       finish;
    logic [2:0] ack_id;
    logic [7:0] isr_set;
    logic [7:0] eoi_clr;
    logic [7:0] aeoi_clr;
    logic [7:0] isr_d;

    always_comb begin
        req_low    = lowest_set(interrupt_request_register & ~interrupt_mask);
        isr_low    = lowest_set(isr_q);
        // Strictly-higher priority than anything in service; req_low == 8
        // (no request) can never be below isr_low.
        cand_valid = (req_low < isr_low);

        inta_fall  = inta_q & ~interrupt_acknowledge_n;
        inta_rise  = ~inta_q & interrupt_acknowledge_n;

        ack_take   = (state_q == REQ) && inta_fall;
        finish     = inta_rise &&
                     (((state_q == ACK1) && (INTA_PULSES == 1)) || (state_q == ACK2));

        ack_id     = cand_valid ? req_low[2:0] : C_SPURIOUS_LVL;

        isr_set    = (ack_take && cand_valid) ? (8'b1 << req_low[2:0]) : 8'h00;

        eoi_clr    = 8'h00;
        if (eoi_cmd) begin
            if (specific_eoi)
                eoi_clr = 8'b1 << eoi_level;
            else if (isr_low != 4'd8)
                eoi_clr = 8'b1 << isr_low[2:0];
        end

        aeoi_clr   = (finish && auto_eoi && id_valid_q) ? (8'b1 << id_q) : 8'h00;

        // Set is applied after clear so a same-bit collision keeps the bit.
        isr_d      = (isr_q & ~(eoi_clr | aeoi_clr)) | isr_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            inta_q       <= 1'b1;
            id_q         <= 3'd0;
            id_valid_q   <= 1'b0;
            isr_q        <= 8'h00;
            int_out_q    <= 1'b0;
            freeze_q     <= 1'b0;
            clear_irr_q  <= 8'h00;
            vector_out_q <= 8'h00;
            vector_oe_q  <= 1'b0;
        end else begin
            inta_q      <= interrupt_acknowledge_n;
            isr_q       <= isr_d;
            clear_irr_q <= isr_set;

            case (state_q)
                IDLE: begin
                    if (cand_valid) begin
                        state_q   <= REQ;
                        int_out_q <= 1'b1;
                    end
                end
                REQ: begin
                    // INTA takes precedence: a request dropping on the same
                    // cycle as the INTA fall becomes a spurious acknowledge.
                    if (inta_fall) begin
                        state_q    <= ACK1;
                        id_q       <= ack_id;
                        id_valid_q <= cand_valid;
                        freeze_q   <= 1'b1;
                        if (INTA_PULSES == 1) begin
                            vector_out_q <= {vector_base, ack_id};
                            vector_oe_q  <= 1'b1;
                            int_out_q    <= 1'b0;
                        end
                    end else if (!cand_valid) begin
                        state_q   <= IDLE;
                        int_out_q <= 1'b0;
                    end
                end
                ACK1: begin
                    if (inta_rise && (INTA_PULSES != 1))
                        state_q <= GAP;
                end
                GAP: begin
                    if (inta_fall) begin
                        state_q      <= ACK2;
                        vector_out_q <= {vector_base, id_q};
                        vector_oe_q  <= 1'b1;
                        int_out_q    <= 1'b0;
                    end
                end
                ACK2: begin
                    // Completion handled below.
                end
                default: state_q <= IDLE;
            endcase

            if (finish) begin
                state_q     <= IDLE;
                vector_oe_q <= 1'b0;
                freeze_q    <= 1'b0;
                int_out_q   <= 1'b0;
            end
        end
    end

    assign int_out             = int_out_q;
    assign freeze              = freeze_q;
    assign clear_IRR           = clear_irr_q;
    assign in_service_register = isr_q;
    assign vector_out          = vector_out_q;
    assign vector_oe           = vector_oe_q;

endmodule
`default_nettype wire
